// File: rtl/vga_pkg.sv
// Shared frame-buffer types and sizing constants for the display path.
package vga_pkg;

  // Frame buffer geometry: one RAM row per display line segment, five 12-bit tiles per row.
  localparam int FRAME_ROWS     = 3840;
  localparam int TILE_BITS      = 12;
  localparam int TILES_PER_ROW  = 5;

  localparam int FBUFF_ADDR_WIDTH_DEF = $clog2(FRAME_ROWS);
  localparam int FBUFF_DATA_WIDTH_DEF = TILE_BITS * TILES_PER_ROW;

  // Arbiter priority state: reads win by default, a write slot is forced after a read burst.
  typedef enum logic {
    RD_PRIO = 1'b0,
    WR_SLOT = 1'b1
  } arb_state_t;

  // Width needed to hold a count from 0 up to and including max_val.
  function automatic int starve_cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fbuff_rd_tracker.sv
// Tracks frame-buffer reads in flight and captures the returned row.
// A tag bit enters the pipe in the grant cycle; after READ_LATENCY cycles the
// RAM is presenting that row on ram_data_i, which is registered together with
// the valid strobe. Reset empties the pipe so no stale return can appear.
module fbuff_rd_tracker #(
  parameter int DATA_W       = 60,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue_i,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [READ_LATENCY-1:0] tag_q;
  logic                    valid_q;
  logic [DATA_W-1:0]       data_q;

  // Shift the read tags one stage per cycle, oldest at the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= issue_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Register the returned row when its tag matures; data holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= tag_q[READ_LATENCY-1];
      if (tag_q[READ_LATENCY-1]) begin
        data_q <= ram_data_i;
      end
    end
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = data_q;

endmodule

// File: rtl/fbuff_port_arbiter.sv
// Cycle-by-cycle arbiter sharing the single-port frame buffer between the
// line-buffer fill engine (reads, display critical) and the pixel writer.
//
// Handshake: a requester raises *_req_i with its address (and data) and holds
// them stable until it sees *_gnt_o high in the same cycle; the grant is the
// acceptance, and the requester may change or drop its request after that edge.
// At most one grant is issued per cycle. Reads return rd_valid_o for exactly one
// cycle per granted read, in grant order; writes have no completion strobe.
module fbuff_port_arbiter
  import vga_pkg::*;
#(
  parameter int FBUFF_ADDR_WIDTH = FBUFF_ADDR_WIDTH_DEF,
  parameter int FBUFF_DATA_WIDTH = FBUFF_DATA_WIDTH_DEF,
  parameter int READ_LATENCY     = 1,
  parameter int MAX_RD_BURST     = 8,
  localparam int CNT_W           = starve_cnt_width(MAX_RD_BURST)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        rd_req_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                        rd_gnt_o,
  output logic [FBUFF_DATA_WIDTH-1:0] rd_data_o,
  output logic                        rd_valid_o,
  input  logic                        wr_req_i,
  input  logic [FBUFF_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [FBUFF_DATA_WIDTH-1:0] wr_data_i,
  output logic                        wr_gnt_o,
  output logic                        fbuff_en_o,
  output logic                        fbuff_wen_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
  output logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_o,
  input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
  output arb_state_t                  dbg_state_o,
  output logic [CNT_W-1:0]            dbg_starve_cnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_t                  state_q;
  logic [CNT_W-1:0]            starve_cnt_q;
  logic                        rd_gnt;
  logic                        wr_gnt;

  logic                        cmd_en_q;
  logic                        cmd_wen_q;
  logic [FBUFF_ADDR_WIDTH-1:0] cmd_addr_q;
  logic [FBUFF_DATA_WIDTH-1:0] cmd_data_q;

  // Grant decision: a lone requester always wins; on contention the state picks.
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (rd_req_i && (!wr_req_i || state_q == RD_PRIO)) begin
      rd_gnt = 1'b1;
    end else if (wr_req_i) begin
      wr_gnt = 1'b1;
    end
  end

  assign rd_gnt_o = rd_gnt;
  assign wr_gnt_o = wr_gnt;

  // Priority FSM and starvation counter. The counter counts reads granted while
  // the writer waits; reaching MAX_RD_BURST hands the next contended cycle to the
  // writer. The write slot lasts one cycle: either the write is granted or the
  // writer has withdrawn, and both cases restart the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RD_PRIO;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        RD_PRIO: begin
          if (!wr_req_i || wr_gnt) begin
            starve_cnt_q <= '0;
          end else if (rd_gnt && starve_cnt_q != MAX_CNT) begin
            starve_cnt_q <= starve_cnt_q + ONE_CNT;
            if (starve_cnt_q == MAX_CNT - ONE_CNT) begin
              state_q <= WR_SLOT;
            end
          end
        end
        WR_SLOT: begin
          starve_cnt_q <= '0;
          state_q      <= RD_PRIO;
        end
      endcase
    end
  end

  // RAM command register: one cycle of enable per grant; address and write data
  // hold their last value on idle cycles so the RAM pins only toggle when used.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_en_q   <= 1'b0;
      cmd_wen_q  <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      cmd_en_q  <= rd_gnt | wr_gnt;
      cmd_wen_q <= wr_gnt;
      if (rd_gnt) begin
        cmd_addr_q <= rd_addr_i;
      end else if (wr_gnt) begin
        cmd_addr_q <= wr_addr_i;
        cmd_data_q <= wr_data_i;
      end
    end
  end

  assign fbuff_en_o   = cmd_en_q;
  assign fbuff_wen_o  = cmd_wen_q;
  assign fbuff_addr_o = cmd_addr_q;
  assign fbuff_data_o = cmd_data_q;

  fbuff_rd_tracker #(
    .DATA_W       (FBUFF_DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_tracker (
    .clk        (clk),
    .rstn       (rstn),
    .issue_i    (rd_gnt),
    .ram_data_i (fbuff_data_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o)
  );

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_cnt_q;

endmodule
